// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divide scheduler.
//   id_width()   : width of a requester index (clog2 of the requester count,
//                  never less than 1 bit).
//   tag_width()  : width of one tag record carried alongside the divider.
//   tag_*_bit/lsb: field positions inside a tag record. The record is packed
//                  MSB to LSB as {valid, id, dz, dividend}.
// -----------------------------------------------------------------------------
package div_pkg;

  function automatic int id_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  function automatic int tag_width(input int n, input int r);
    return 1 + id_width(r) + 1 + n;
  endfunction

  // dividend occupies [n-1:0]
  function automatic int tag_dz_bit(input int n);
    return n;
  endfunction

  function automatic int tag_id_lsb(input int n);
    return n + 1;
  endfunction

  function automatic int tag_valid_bit(input int n, input int r);
    return n + 1 + id_width(r);
  endfunction

endpackage

// File: rtl/div_sched_div.sv
// -----------------------------------------------------------------------------
// div_sched_div
// Unsigned N-bit divider with a fixed latency of LAT clock cycles (LAT >= 1).
// The quotient/remainder are formed combinationally from the inputs and then
// pass through LAT register stages; synthesis retiming is expected to spread
// the divide array across those stages. A zero divisor yields q=0, r=dividend;
// the caller overrides that case anyway.
//   i_clk        : clock
//   i_dividend   : N-bit dividend
//   i_divisor    : N-bit divisor
//   o_quotient   : quotient, LAT cycles after the inputs
//   o_remainder  : remainder, LAT cycles after the inputs
// -----------------------------------------------------------------------------
module div_sched_div #(
  parameter int N   = 8,
  parameter int LAT = N
) (
  input  logic         i_clk,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder
);

  logic [N-1:0] w_q;
  logic [N-1:0] w_r;
  logic [N-1:0] r_q [LAT];
  logic [N-1:0] r_r [LAT];

  always_comb begin
    w_q = '0;
    w_r = i_dividend;
    if (i_divisor != '0) begin
      w_q = i_dividend / i_divisor;
      w_r = i_dividend % i_divisor;
    end
  end

  // Pure datapath: no reset needed, validity travels in the caller's tags.
  always_ff @(posedge i_clk) begin
    r_q[0] <= w_q;
    r_r[0] <= w_r;
    for (int s = 1; s < LAT; s++) begin
      r_q[s] <= r_q[s-1];
      r_r[s] <= r_r[s-1];
    end
  end

  assign o_quotient  = r_q[LAT-1];
  assign o_remainder = r_r[LAT-1];

endmodule

// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched
// Round-robin scheduler sharing one pipelined divider among R requesters.
// Handshake: request i is accepted on a rising edge where req_valid[i] and
// req_grant[i] are both high; req_grant is combinational, at most one-hot, and
// a requester may hold req_valid until it sees its grant. Results come back in
// acceptance order, LAT+1 edges after acceptance, as a one-cycle resp_valid
// strobe; all resp_* fields read 0 when resp_valid is low.
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid[R]               : request strobes
//   req_dividend/req_divisor   : packed operands, lane i at [i*N +: N]
//   req_grant[R]               : combinational grant
//   resp_valid/resp_id         : result strobe and owning requester
//   resp_quotient/remainder    : unsigned result
//   resp_dz                    : divide-by-zero (q = all ones, r = dividend)
// -----------------------------------------------------------------------------
module div_sched import div_pkg::*; #(
  parameter int N   = 8,
  parameter int R   = 4,
  parameter int LAT = N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [R-1:0]            req_valid,
  input  logic [R*N-1:0]          req_dividend,
  input  logic [R*N-1:0]          req_divisor,
  output logic [R-1:0]            req_grant,
  output logic                    resp_valid,
  output logic [id_width(R)-1:0]  resp_id,
  output logic [N-1:0]            resp_quotient,
  output logic [N-1:0]            resp_remainder,
  output logic                    resp_dz
);

  localparam int IDW  = id_width(R);
  localparam int TW   = tag_width(N, R);
  localparam int T_DZ = tag_dz_bit(N);
  localparam int T_ID = tag_id_lsb(N);
  localparam int T_V  = tag_valid_bit(N, R);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_gnt_idx;
  logic           w_accept;
  logic [R-1:0]   w_grant;
  logic [IDW:0]   w_c;
  logic [IDW-1:0] w_ptr_nxt;
  logic [N-1:0]   w_sel_dvd;
  logic [N-1:0]   w_sel_dvs;
  logic [N-1:0]   r_iss_dvd;
  logic [N-1:0]   r_iss_dvs;
  logic [TW-1:0]  r_tag [LAT+1];
  logic [N-1:0]   w_div_q;
  logic [N-1:0]   w_div_r;

  // Scan the requesters starting at the pointer; the first valid one wins.
  // w_c is one bit wider than an index so ptr+k cannot overflow before wrap.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_accept  = 1'b0;
    w_c       = '0;
    for (int k = 0; k < R; k++) begin
      w_c = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_c >= (IDW+1)'(R)) w_c = w_c - (IDW+1)'(R);
      if (!w_accept && req_valid[w_c[IDW-1:0]]) begin
        w_accept  = 1'b1;
        w_gnt_idx = w_c[IDW-1:0];
      end
    end
    if (rst) w_accept = 1'b0;
    if (w_accept) w_grant[w_gnt_idx] = 1'b1;
  end

  assign req_grant = w_grant;

  always_comb begin
    w_ptr_nxt = w_gnt_idx + IDW'(1);
    if (int'(w_gnt_idx) == R - 1) w_ptr_nxt = '0;
  end

  assign w_sel_dvd = req_dividend[int'(w_gnt_idx)*N +: N];
  assign w_sel_dvs = req_divisor[int'(w_gnt_idx)*N +: N];

  div_sched_div #(.N(N), .LAT(LAT)) u_div (
    .i_clk       (clk),
    .i_dividend  (r_iss_dvd),
    .i_divisor   (r_iss_dvs),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_r)
  );

  // r_tag[0] is loaded on the same edge as the issue register, so r_tag[LAT]
  // lines up with the divider output and the response registers one edge on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr          <= '0;
      r_iss_dvd      <= '0;
      r_iss_dvs      <= '0;
      for (int s = 0; s <= LAT; s++) r_tag[s] <= '0;
      resp_valid     <= 1'b0;
      resp_id        <= '0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_dz        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr     <= w_ptr_nxt;
        r_iss_dvd <= w_sel_dvd;
        r_iss_dvs <= w_sel_dvs;
        r_tag[0]  <= {1'b1, w_gnt_idx, (w_sel_dvs == '0), w_sel_dvd};
      end else begin
        r_tag[0]  <= '0;
      end
      for (int s = 1; s <= LAT; s++) r_tag[s] <= r_tag[s-1];

      if (r_tag[LAT][T_V]) begin
        resp_valid <= 1'b1;
        resp_id    <= r_tag[LAT][T_ID +: IDW];
        resp_dz    <= r_tag[LAT][T_DZ];
        if (r_tag[LAT][T_DZ]) begin
          resp_quotient  <= '1;
          resp_remainder <= r_tag[LAT][N-1:0];
        end else begin
          resp_quotient  <= w_div_q;
          resp_remainder <= w_div_r;
        end
      end else begin
        resp_valid     <= 1'b0;
        resp_id        <= '0;
        resp_quotient  <= '0;
        resp_remainder <= '0;
        resp_dz        <= 1'b0;
      end
    end
  end

endmodule
